// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing input PIO: bus widths, register
// addresses and the EDGE_TYPE / IRQ_MODE parameter encodings.
package pio_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    localparam int unsigned IRQ_LEVEL = 0;
    localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave port of the input PIO: word address, chip select,
// active-low write strobe, write data and registered read data.
interface pio_in_edge_irq_if;
    import pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser followed by an optional stability
// counter that only lets the bit change after DEBOUNCE_CYCLES steady cycles.
module pio_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter logic        RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic deb_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= in_i;
            sync_q <= meta_q;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign deb_o = sync_q;
    end else begin : g_debounce
        localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_q, deb_d;

        // Any cycle where the synchronised bit agrees with the output restarts the count
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (sync_q != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d = sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                deb_q <= RESET_VALUE;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign deb_o = deb_q;
    end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Input PIO for switches/buttons: synchronised and debounced inputs, sticky
// edge capture with write-1-to-clear, interrupt mask and level/edge IRQ.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int unsigned     WIDTH           = 18,
    parameter int unsigned     EDGE_TYPE       = EDGE_RISE,
    parameter int unsigned     IRQ_MODE        = IRQ_LEVEL,
    parameter int unsigned     DEBOUNCE_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_in_edge_irq_if.slave     bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [WIDTH-1:0]  deb;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [WIDTH-1:0]  clr;
    logic [WIDTH-1:0]  rise, fall, edge_hit;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              irq_q, irq_d;
    logic              wr_en;
    logic              unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_bit (
            .clk     (clk),
            .reset_n (reset_n),
            .in_i    (in_port[i]),
            .deb_o   (deb[i])
        );
    end

    assign rise  = deb & ~prev_q;
    assign fall  = ~deb & prev_q;
    assign wr_en = bus.chipselect & ~bus.write_n;

    // Bits above WIDTH carry no register state
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        edge_hit = rise;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_hit = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_hit = rise | fall;
        end
    end

    // Register updates; a new edge wins over a same-cycle clear of that bit
    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && (bus.address == ADDR_MASK)) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && (bus.address == ADDR_EDGE)) begin
            clr = bus.writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~clr) | edge_hit;

        case (bus.address)
            ADDR_DATA: rdata_d = DATA_W'(deb);
            ADDR_MASK: rdata_d = DATA_W'(mask_q);
            ADDR_EDGE: rdata_d = DATA_W'(cap_q);
            default:   rdata_d = '0;
        endcase

        irq_d = (IRQ_MODE == IRQ_EDGE) ? |(cap_q & mask_q) : |(deb & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= RESET_VALUE;
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            prev_q  <= deb;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: five differently-configured instances driven by
// directed vectors, expected values queued and checked by a separate monitor.
module tb_pio_in_edge_irq;
    import pio_pkg::*;

    localparam int unsigned N = 5;

    typedef struct {
        int          inst;
        bit          is_irq;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  addr_a [N];
    logic        cs_a   [N];
    logic        wn_a   [N];
    logic [31:0] wd_a   [N];
    logic [17:0] in_a   [N];
    logic [31:0] rd_a   [N];
    logic        irq_a  [N];
    logic        req;

    exp_t        sb_q [$];
    exp_t        e;
    logic [31:0] act;
    int          n_checks;
    int          n_fail;

    pio_in_edge_irq_if bus0 ();
    pio_in_edge_irq_if bus1 ();
    pio_in_edge_irq_if bus2 ();
    pio_in_edge_irq_if bus3 ();
    pio_in_edge_irq_if bus4 ();

    assign bus0.address = addr_a[0]; assign bus0.chipselect = cs_a[0];
    assign bus0.write_n = wn_a[0];   assign bus0.writedata  = wd_a[0];
    assign bus1.address = addr_a[1]; assign bus1.chipselect = cs_a[1];
    assign bus1.write_n = wn_a[1];   assign bus1.writedata  = wd_a[1];
    assign bus2.address = addr_a[2]; assign bus2.chipselect = cs_a[2];
    assign bus2.write_n = wn_a[2];   assign bus2.writedata  = wd_a[2];
    assign bus3.address = addr_a[3]; assign bus3.chipselect = cs_a[3];
    assign bus3.write_n = wn_a[3];   assign bus3.writedata  = wd_a[3];
    assign bus4.address = addr_a[4]; assign bus4.chipselect = cs_a[4];
    assign bus4.write_n = wn_a[4];   assign bus4.writedata  = wd_a[4];

    assign rd_a[0] = bus0.readdata;
    assign rd_a[1] = bus1.readdata;
    assign rd_a[2] = bus2.readdata;
    assign rd_a[3] = bus3.readdata;
    assign rd_a[4] = bus4.readdata;

    // Level IRQ, rising edges, no debounce
    pio_in_edge_irq u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_a[0]), .irq(irq_a[0]));
    pio_in_edge_irq #(.IRQ_MODE(IRQ_EDGE)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_a[1]), .irq(irq_a[1]));
    pio_in_edge_irq #(.IRQ_MODE(IRQ_EDGE), .DEBOUNCE_CYCLES(8)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_a[2]), .irq(irq_a[2]));
    pio_in_edge_irq #(.IRQ_MODE(IRQ_EDGE), .EDGE_TYPE(EDGE_FALL)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3), .in_port(in_a[3]), .irq(irq_a[3]));
    pio_in_edge_irq #(.IRQ_MODE(IRQ_EDGE), .EDGE_TYPE(EDGE_ANY)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4), .in_port(in_a[4]), .irq(irq_a[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus cycle issued at a negedge; optionally checks readdata after the next posedge
    task automatic bus_op(input int k, input logic [1:0] a, input bit we,
                          input logic [31:0] wd, input bit chk,
                          input logic [31:0] exp, input string name);
        exp_t item;
        addr_a[k] = a;
        cs_a[k]   = 1'b1;
        wn_a[k]   = ~we;
        wd_a[k]   = wd;
        if (chk) begin
            item = '{k, 1'b0, exp, name};
            sb_q.push_back(item);
            req = 1'b1;
        end
        @(negedge clk);
        cs_a[k] = 1'b0;
        wn_a[k] = 1'b1;
        req     = 1'b0;
    endtask

    task automatic rd(input int k, input logic [1:0] a, input logic [31:0] exp, input string name);
        bus_op(k, a, 1'b0, 32'h0, 1'b1, exp, name);
    endtask

    task automatic wr(input int k, input logic [1:0] a, input logic [31:0] d);
        bus_op(k, a, 1'b1, d, 1'b0, 32'h0, "");
    endtask

    task automatic irq_chk(input int k, input bit exp, input string name);
        exp_t item;
        item = '{k, 1'b1, {31'h0, exp}, name};
        sb_q.push_back(item);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    // Monitor: outputs are sampled 1 ns after the posedge that follows a request
    initial begin
        forever begin
            @(posedge clk);
            if (req) begin
                #1;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty: request with nothing queued");
                end else begin
                    e   = sb_q.pop_front();
                    act = e.is_irq ? {31'h0, irq_a[e.inst]} : rd_a[e.inst];
                    if (act !== e.val) begin
                        n_fail++;
                        $display("FAIL %s: dut%0d got 0x%0h, expected 0x%0h",
                                 e.name, e.inst, act, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        req      = 1'b0;
        reset_n  = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = 2'd0;
            cs_a[i]   = 1'b0;
            wn_a[i]   = 1'b1;
            wd_a[i]   = 32'h0;
            in_a[i]   = 18'h0;
        end
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Reset state
        rd(0, 2'd0, 32'h0, "rst_data");
        rd(0, 2'd1, 32'h0, "rst_addr1");
        rd(0, 2'd2, 32'h0, "rst_mask");
        rd(0, 2'd3, 32'h0, "rst_cap");
        irq_chk(0, 1'b0, "rst_irq0");
        irq_chk(1, 1'b0, "rst_irq1");

        // Level IRQ latency: asserts on the third edge after the drive
        wr(0, ADDR_MASK, 32'h4);
        rd(0, ADDR_MASK, 32'h4, "lvl_mask");
        in_a[0] = 18'h4;
        irq_chk(0, 1'b0, "lvl_e1");
        irq_chk(0, 1'b0, "lvl_e2");
        irq_chk(0, 1'b1, "lvl_e3");
        rd(0, ADDR_DATA, 32'h4, "lvl_data");
        in_a[0] = 18'h0;
        irq_chk(0, 1'b1, "lvl_off_e1");
        irq_chk(0, 1'b1, "lvl_off_e2");
        irq_chk(0, 1'b0, "lvl_off_e3");
        in_a[0] = 18'h2;
        tick(4);
        irq_chk(0, 1'b0, "lvl_unmasked");
        rd(0, ADDR_DATA, 32'h2, "lvl_data_b1");
        rd(0, ADDR_EDGE, 32'h6, "lvl_cap");
        rd(0, 2'd1, 32'h0, "addr1_zero");
        in_a[0] = 18'h0;

        // Edge IRQ: one-cycle pulse is captured, sticky, then W1C
        wr(1, ADDR_MASK, 32'hFFFF_FFFF);
        rd(1, ADDR_MASK, 32'h0003_FFFF, "mask_width");
        in_a[1] = 18'h1;
        tick(1);
        in_a[1] = 18'h0;
        tick(4);
        rd(1, ADDR_EDGE, 32'h1, "pulse_cap");
        irq_chk(1, 1'b1, "pulse_irq");
        tick(5);
        rd(1, ADDR_EDGE, 32'h1, "pulse_sticky");
        bus_op(1, ADDR_EDGE, 1'b1, 32'h1, 1'b1, 32'h1, "w1c_reads_old");
        irq_chk(1, 1'b0, "w1c_irq_drop");
        rd(1, ADDR_EDGE, 32'h0, "w1c_cap");

        // Clear and new edge on the same bit in the same cycle
        in_a[1] = 18'h20;
        tick(4);
        rd(1, ADDR_EDGE, 32'h20, "b5_cap");
        in_a[1] = 18'h0;
        tick(4);
        rd(1, ADDR_EDGE, 32'h20, "rise_only");
        in_a[1] = 18'h20;
        tick(2);
        bus_op(1, ADDR_EDGE, 1'b1, 32'h20, 1'b1, 32'h20, "race_rd");
        rd(1, ADDR_EDGE, 32'h20, "race_set_wins");
        wr(1, ADDR_EDGE, 32'h20);
        rd(1, ADDR_EDGE, 32'h0, "race_clr");

        // Debounce of 8: a 5-cycle glitch is rejected, a steady level passes after 3+8
        in_a[2] = 18'h2;
        tick(5);
        in_a[2] = 18'h0;
        tick(20);
        rd(2, ADDR_DATA, 32'h0, "glitch_data");
        rd(2, ADDR_EDGE, 32'h0, "glitch_cap");
        in_a[2] = 18'h2;
        tick(9);
        rd(2, ADDR_DATA, 32'h0, "deb_early");
        rd(2, ADDR_DATA, 32'h2, "deb_exact");
        rd(2, ADDR_EDGE, 32'h2, "deb_cap");
        tick(8);
        in_a[2] = 18'h0;
        tick(12);
        rd(2, ADDR_DATA, 32'h0, "deb_release");

        // Falling-edge capture
        wr(3, ADDR_MASK, 32'h8);
        in_a[3] = 18'h8;
        tick(5);
        rd(3, ADDR_EDGE, 32'h0, "fall_no_rise");
        irq_chk(3, 1'b0, "fall_irq_idle");
        in_a[3] = 18'h0;
        tick(5);
        rd(3, ADDR_EDGE, 32'h8, "fall_cap");
        irq_chk(3, 1'b1, "fall_irq");

        // Any-edge capture with a clear between the two edges
        in_a[4] = 18'h8;
        tick(4);
        rd(4, ADDR_EDGE, 32'h8, "any_rise");
        bus_op(4, ADDR_EDGE, 1'b1, 32'h8, 1'b1, 32'h8, "any_w1c_rd");
        rd(4, ADDR_EDGE, 32'h0, "any_clr");
        in_a[4] = 18'h0;
        tick(4);
        rd(4, ADDR_EDGE, 32'h8, "any_fall");

        // Reset mid-operation: pending edges dropped, debounce restarts from zero
        in_a[1] = 18'h21;
        in_a[2] = 18'h2;
        tick(4);
        rd(1, ADDR_EDGE, 32'h1, "pre_rst_cap");
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        rd(1, ADDR_EDGE, 32'h0, "post_rst_cap");
        rd(1, ADDR_MASK, 32'h0, "post_rst_mask");
        irq_chk(1, 1'b0, "post_rst_irq");
        tick(6);
        rd(2, ADDR_DATA, 32'h0, "post_rst_deb_early");
        rd(2, ADDR_DATA, 32'h2, "post_rst_deb_exact");

        tick(2);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
